// File: rtl/mult_rr_scheduler.sv
// Round-robin arbiter sharing one sequential shift-add multiplier (rca_mult) among NUM_REQ clients.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip the multiplier and complete one cycle after accept.
module mult_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MULT_LAT   = DATA_WIDTH + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]              resp_valid_o,
  output logic [2*DATA_WIDTH-1:0]         resp_result_o,
  output logic                            busy_o,
  output logic                            mult_enable_o,
  output logic [DATA_WIDTH-1:0]           mult_a_o,
  output logic [DATA_WIDTH-1:0]           mult_b_o,
  input  logic [2*DATA_WIDTH-1:0]         mult_result_i
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MULT_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [DATA_WIDTH-1:0]   mult_b_q, mult_b_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic                    en_q, en_d;
  logic                    busy_q, busy_d;

  logic                    grant_any_s;
  logic [PW-1:0]           grant_idx_s;
  logic [NUM_REQ-1:0]      grant_s;
  logic [DATA_WIDTH-1:0]   sel_a_s, sel_b_s;
  logic                    accept_s;

  // Scan from rr_ptr downwards in priority; the lowest offset from rr_ptr wins.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = {PW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx         = (int'(rr_ptr_q) + k) % NUM_REQ;
      grant_any_s = req_valid_i[idx] ? 1'b1 : grant_any_s;
      grant_idx_s = req_valid_i[idx] ? PW'(idx) : grant_idx_s;
    end
    grant_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    sel_a_s  = req_a_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    sel_b_s  = req_b_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    accept_s = (state_q == IDLE) && grant_any_s && !rst_i;
  end

  assign req_ready_o = accept_s ? grant_s : {NUM_REQ{1'b0}};

  // Next-state and datapath updates for the grant/load/run/respond sequence.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          mult_a_d = sel_a_s;
          mult_b_d = sel_b_s;
          owner_d  = grant_idx_s;
          rr_ptr_d = PW'((int'(grant_idx_s) + 1) % NUM_REQ);
`ifdef MULT_ZERO_BYPASS_EN
          if ((sel_a_s == {DATA_WIDTH{1'b0}}) || (sel_b_s == {DATA_WIDTH{1'b0}})) begin
            state_d  = DONE;
            result_d = {(2*DATA_WIDTH){1'b0}};
          end else begin
            state_d  = LOAD;
          end
`else
          state_d = LOAD;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = CW'(MULT_LAT - 1);
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == {CW{1'b0}}) begin
          result_d = mult_result_i;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    en_d         = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == DONE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_d)
                                     : {NUM_REQ{1'b0}};
  end

  // State and output registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= {PW{1'b0}};
      owner_q      <= {PW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      mult_a_q     <= {DATA_WIDTH{1'b0}};
      mult_b_q     <= {DATA_WIDTH{1'b0}};
      result_q     <= {(2*DATA_WIDTH){1'b0}};
      resp_valid_q <= {NUM_REQ{1'b0}};
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = result_q;
  assign busy_o        = busy_q;
  assign mult_enable_o = en_q;
  assign mult_a_o      = mult_a_q;
  assign mult_b_o      = mult_b_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Randomised scoreboard bench for mult_rr_scheduler with a bit-serial shift-add multiplier model.
module tb_mult_rr_scheduler;

  localparam int DW = 32;
  localparam int NR = 4;
`ifdef MULT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int FULL_LAT = DW + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     a_s [NR];
  logic [DW-1:0]     b_s [NR];
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR-1:0]     resp_valid;
  logic [2*DW-1:0]   resp_result;
  logic              busy, mult_enable;
  logic [DW-1:0]     mult_a, mult_b;
  logic [2*DW-1:0]   mult_result;

  assign req_a = {a_s[3], a_s[2], a_s[1], a_s[0]};
  assign req_b = {b_s[3], b_s[2], b_s[1], b_s[0]};

  always #5 clk = ~clk;

  mult_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .resp_valid_o(resp_valid), .resp_result_o(resp_result),
    .busy_o(busy), .mult_enable_o(mult_enable),
    .mult_a_o(mult_a), .mult_b_o(mult_b),
    .mult_result_i(mult_result)
  );

  // Sequential shift-add multiplier: enable low loads operands, each enabled cycle adds one bit.
  logic [2*DW-1:0] m_acc = '0;
  logic [DW-1:0]   m_a = '0, m_b = '0;
  int              m_k = 0;
  assign mult_result = m_acc;
  always @(posedge clk) begin
    if (!mult_enable) begin
      m_acc <= '0; m_a <= mult_a; m_b <= mult_b; m_k <= 0;
    end else if (m_k < DW) begin
      if (m_b[m_k]) m_acc <= m_acc + ((2*DW)'(m_a) << m_k);
      m_k <= m_k + 1;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct { logic [63:0] prod; int due; } exp_t;
  exp_t sb [NR][$];

  // Reference model: round-robin pointer and remaining-cycles counter per operation.
  int rr = 0, cnt_m = 0, cyc_m = 0;
  bit byp_m = 1'b0, post_rst = 1'b0;
  int accepts [NR] = '{default: 0};
  always @(negedge clk) begin
    cyc_m++;
    if (rst) begin
      rr = 0; cnt_m = 0; post_rst = 1'b1;
      for (int i = 0; i < NR; i++) sb[i].delete();
      chk("ready_in_reset", req_ready, 0);
    end else begin
      if (post_rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_enable", mult_enable, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
        post_rst = 1'b0;
      end
      if (cnt_m == 0) begin
        int g;
        logic [NR-1:0] exp_rdy;
        g = -1;
        for (int k = 0; k < NR; k++)
          if (g < 0 && req_valid[(rr + k) % NR]) g = (rr + k) % NR;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("grant", req_ready, exp_rdy);
        chk("idle_busy", busy, 0);
        chk("idle_enable", mult_enable, 0);
        if (g >= 0) begin
          exp_t e;
          byp_m  = BYP && (a_s[g] == 0 || b_s[g] == 0);
          cnt_m  = byp_m ? 1 : FULL_LAT;
          e.prod = 64'(a_s[g]) * 64'(b_s[g]);
          e.due  = cyc_m + cnt_m;
          sb[g].push_back(e);
          rr = (g + 1) % NR;
          accepts[g]++;
        end
      end else begin
        chk("busy_ready", req_ready, 0);
        chk("busy", busy, 1);
        chk("mult_enable", mult_enable, (!byp_m && cnt_m >= 2 && cnt_m <= FULL_LAT - 1) ? 1 : 0);
        cnt_m--;
      end
    end
  end

  // Monitor: pops the owner's scoreboard on every response and checks value and timing.
  int cyc_mon = 0;
  logic [63:0] last_res = '0;
  always @(negedge clk) begin
    cyc_mon++;
    if (rst) begin
      last_res = '0;
    end else begin
      if (resp_valid != 0) begin
        chk("resp_onehot", $countones(resp_valid), 1);
        for (int i = 0; i < NR; i++) begin
          if (resp_valid[i]) begin
            if (sb[i].size() == 0) begin
              nchk++; nerr++;
              $display("FAIL resp_unexpected: requester %0d got %h expected no response", i, resp_result);
            end else begin
              exp_t e;
              e = sb[i].pop_front();
              chk("resp_result", resp_result, e.prod);
              chk("resp_cycle", cyc_mon, e.due);
              last_res = e.prod;
            end
          end
        end
      end else begin
        chk("result_hold", resp_result, last_res);
      end
      for (int i = 0; i < NR; i++) begin
        if (sb[i].size() != 0 && sb[i][0].due < cyc_mon) begin
          nchk++; nerr++;
          $display("FAIL resp_missing: requester %0d got none expected %h at cycle %0d",
                   i, sb[i][0].prod, sb[i][0].due);
          void'(sb[i].pop_front());
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_op();
    case ($urandom % 8)
      0: return '0;
      1: return '1;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] v, input int hold);
    req_valid = v;
    wait_cyc(hold);
    req_valid = '0;
  endtask

  initial begin
    int base [NR];
    int guard;
    bit done;
    rst = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) begin a_s[i] = DW'(i + 1); b_s[i] = DW'(i + 2); end
    wait_cyc(3);
    rst = 1'b0;
    a_s[0] = 32'd3; b_s[0] = 32'd5;
    drive(4'b0001, 1);
    wait_cyc(40);
    a_s[3] = 32'hFFFF_FFFF; b_s[3] = 32'hFFFF_FFFF;
    drive(4'b1000, 1);
    wait_cyc(40);
    for (int i = 0; i < NR; i++) begin a_s[i] = DW'(100 + i); b_s[i] = DW'(7 * i + 9); end
    drive(4'b1111, 4 * (FULL_LAT + 1) + 1);
    wait_cyc(40);
    a_s[1] = 32'd1234; b_s[1] = 32'd777;
    drive(4'b0010, 1);
    wait_cyc(10);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    a_s[2] = 32'd6; b_s[2] = 32'd9;
    drive(4'b1100, 1);
    wait_cyc(40);
    a_s[0] = 32'd0; b_s[0] = 32'd7;
    drive(4'b0001, 1);
    wait_cyc(40);

    for (int i = 0; i < NR; i++) base[i] = accepts[i];
    guard = 0;
    done = 1'b0;
    while (!done && guard < 60000) begin
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin a_s[i] = rnd_op(); b_s[i] = rnd_op(); end
      wait_cyc(1);
      guard++;
      done = 1'b1;
      for (int i = 0; i < NR; i++) if (accepts[i] - base[i] < 50) done = 1'b0;
    end
    if (!done) begin
      nchk++; nerr++;
      $display("FAIL random_budget: got incomplete request counts expected 50 per requester");
    end
    req_valid = '0;
    wait_cyc(50);
    for (int i = 0; i < NR; i++) chk("drain", sb[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
